// File: rtl/pipe_control_pkg.sv
// Shared encodings, stage-control bundles and condition evaluation for the
// LEGv8 pipeline controller.
package pipe_control_pkg;

    localparam int PKG_XFER_W = 4;
    localparam int PKG_REG_W  = 5;

    // Opcode prefixes of instruction[31:21]; shorter prefixes cover immediate/offset bits.
    localparam logic [9:0]  OPC_ADDI  = 10'b1001000100;
    localparam logic [10:0] OPC_ADDS  = 11'b10101011000;
    localparam logic [10:0] OPC_SUBS  = 11'b11101011000;
    localparam logic [5:0]  OPC_B     = 6'b000101;
    localparam logic [7:0]  OPC_BCOND = 8'b01010100;
    localparam logic [7:0]  OPC_CBZ   = 8'b10110100;
    localparam logic [7:0]  OPC_CBNZ  = 8'b10110101;
    localparam logic [10:0] OPC_LDUR  = 11'b11111000010;
    localparam logic [10:0] OPC_LDURB = 11'b00111000010;
    localparam logic [10:0] OPC_STUR  = 11'b11111000000;
    localparam logic [10:0] OPC_STURB = 11'b00111000000;
    localparam logic [8:0]  OPC_MOVZ  = 9'b110100101;
    localparam logic [8:0]  OPC_MOVK  = 9'b111100101;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_HS = 4'h2, COND_LO = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_t;

    typedef enum logic [3:0] {
        OP_NONE, OP_ADDI, OP_ADDS, OP_SUBS, OP_B, OP_BCOND, OP_CBZ,
        OP_CBNZ, OP_LDUR, OP_LDURB, OP_STUR, OP_STURB, OP_MOVZ, OP_MOVK
    } op_t;

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_PASSB  = 3'd2;
    localparam logic [2:0] ALU_MOVZ   = 3'd3;
    localparam logic [2:0] ALU_MOVK   = 3'd4;

    localparam logic [1:0] SRC_REG    = 2'd0;
    localparam logic [1:0] SRC_IMM12  = 2'd1;
    localparam logic [1:0] SRC_DADDR  = 2'd2;
    localparam logic [1:0] SRC_MOVIMM = 2'd3;

    localparam logic [1:0] WB_ALU     = 2'd0;
    localparam logic [1:0] WB_MEM     = 2'd1;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [1:0] alu_src;
        logic       set_flag;
        logic       valid;
    } ex_ctrl_t;

    typedef struct packed {
        logic                  mem_write;
        logic                  mem_read;
        logic                  load_b;
        logic [PKG_XFER_W-1:0] xfer_size;
        logic                  valid;
    } mem_ctrl_t;

    typedef struct packed {
        logic                 reg_write;
        logic [1:0]           mem_to_reg;
        logic [PKG_REG_W-1:0] rd;
        logic                 valid;
    } wb_ctrl_t;

    localparam ex_ctrl_t  EX_BUBBLE  = '0;
    localparam mem_ctrl_t MEM_BUBBLE = '0;
    localparam wb_ctrl_t  WB_BUBBLE  = '0;

    // nzvc is packed {N, Z, V, C}.
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzvc);
        logic n, z, v, c, hold;
        {n, z, v, c} = nzvc;
        hold = 1'b1;
        case (cond)
            COND_EQ: hold = z;
            COND_NE: hold = !z;
            COND_HS: hold = c;
            COND_LO: hold = !c;
            COND_MI: hold = n;
            COND_PL: hold = !n;
            COND_VS: hold = v;
            COND_VC: hold = !v;
            COND_HI: hold = c && !z;
            COND_LS: hold = !(c && !z);
            COND_GE: hold = (n == v);
            COND_LT: hold = (n != v);
            COND_GT: hold = !z && (n == v);
            COND_LE: hold = !(!z && (n == v));
            default: hold = 1'b1;
        endcase
        return hold;
    endfunction

endpackage

// File: rtl/pipe_control_decode.sv
// Combinational ID-stage decoder: classifies the instruction and builds the
// control bundles that travel down the pipeline, plus register-field taps.
module ctrl_decode
    import pipe_control_pkg::*;
#(
    parameter int XFER_W = PKG_XFER_W,
    parameter int REG_W  = PKG_REG_W
) (
    input  logic             instr_valid,
    input  logic [31:0]      instruction,
    output op_t              op,
    output ex_ctrl_t         ex_bundle,
    output mem_ctrl_t        mem_bundle,
    output wb_ctrl_t         wb_bundle,
    output logic             reg2loc,
    output logic [REG_W-1:0] rn,
    output logic [REG_W-1:0] rt,
    output logic [REG_W-1:0] src2,
    output logic [3:0]       cond
);

    logic [10:0] opc;
    logic        unused_shamt;

    assign opc          = instruction[31:21];
    assign unused_shamt = ^instruction[15:10];
    assign rn           = REG_W'(instruction[9:5]);
    assign rt           = REG_W'(instruction[4:0]);
    assign cond         = instruction[3:0];
    assign src2         = reg2loc ? REG_W'(instruction[20:16]) : rt;

    always_comb begin
        op = OP_NONE;
        if (opc[10:1] == OPC_ADDI)      op = OP_ADDI;
        else if (opc == OPC_ADDS)       op = OP_ADDS;
        else if (opc == OPC_SUBS)       op = OP_SUBS;
        else if (opc[10:5] == OPC_B)    op = OP_B;
        else if (opc[10:3] == OPC_BCOND) op = OP_BCOND;
        else if (opc[10:3] == OPC_CBZ)  op = OP_CBZ;
        else if (opc[10:3] == OPC_CBNZ) op = OP_CBNZ;
        else if (opc == OPC_LDUR)       op = OP_LDUR;
        else if (opc == OPC_LDURB)      op = OP_LDURB;
        else if (opc == OPC_STUR)       op = OP_STUR;
        else if (opc == OPC_STURB)      op = OP_STURB;
        else if (opc[10:2] == OPC_MOVZ) op = OP_MOVZ;
        else if (opc[10:2] == OPC_MOVK) op = OP_MOVK;
        if (!instr_valid) op = OP_NONE;
    end

    // Undefined opcodes fall through to all-zero bubbles.
    always_comb begin
        ex_bundle  = EX_BUBBLE;
        mem_bundle = MEM_BUBBLE;
        wb_bundle  = WB_BUBBLE;
        reg2loc    = 1'b0;
        wb_bundle.rd = REG_W'(instruction[4:0]);
        if (op != OP_NONE) begin
            ex_bundle.valid  = 1'b1;
            mem_bundle.valid = 1'b1;
            wb_bundle.valid  = 1'b1;
        end
        case (op)
            OP_ADDI: begin
                ex_bundle.alu_src   = SRC_IMM12;
                wb_bundle.reg_write = 1'b1;
            end
            OP_ADDS, OP_SUBS: begin
                ex_bundle.alu_op    = (op == OP_SUBS) ? ALU_SUB : ALU_ADD;
                ex_bundle.set_flag  = 1'b1;
                wb_bundle.reg_write = 1'b1;
                reg2loc             = 1'b1;
            end
            OP_CBZ, OP_CBNZ: ex_bundle.alu_op = ALU_PASSB;
            OP_LDUR, OP_LDURB: begin
                ex_bundle.alu_src    = SRC_DADDR;
                mem_bundle.mem_read  = 1'b1;
                mem_bundle.load_b    = (op == OP_LDURB);
                mem_bundle.xfer_size = (op == OP_LDURB) ? XFER_W'(1) : XFER_W'(8);
                wb_bundle.reg_write  = 1'b1;
                wb_bundle.mem_to_reg = WB_MEM;
            end
            OP_STUR, OP_STURB: begin
                ex_bundle.alu_src    = SRC_DADDR;
                mem_bundle.mem_write = 1'b1;
                mem_bundle.xfer_size = (op == OP_STURB) ? XFER_W'(1) : XFER_W'(8);
            end
            OP_MOVZ, OP_MOVK: begin
                ex_bundle.alu_op    = (op == OP_MOVK) ? ALU_MOVK : ALU_MOVZ;
                ex_bundle.alu_src   = SRC_MOVIMM;
                wb_bundle.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipe_control.sv
// Pipeline controller: hazard detection, ID-stage branch resolution, NZVC flag
// register and the ID->EX->MEM->WB control-bundle registers.
module pipe_control
    import pipe_control_pkg::*;
#(
    parameter int XFER_W = PKG_XFER_W,
    parameter int REG_W  = PKG_REG_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instruction,
    input  logic        rd_is_zero,
    input  logic        ex_negative,
    input  logic        ex_zero,
    input  logic        ex_overflow,
    input  logic        ex_carry,
    output logic        stall,
    output logic        flush_if,
    output logic        br_taken,
    output logic        uncond_br,
    output logic        reg2loc,
    output ex_ctrl_t    ex_ctrl,
    output mem_ctrl_t   mem_ctrl,
    output wb_ctrl_t    wb_ctrl
);

    localparam logic [REG_W-1:0] XZR = '1;

    op_t              op;
    ex_ctrl_t         dec_ex, ex_q;
    mem_ctrl_t        dec_mem, ex_mem_q, mem_q;
    wb_ctrl_t         dec_wb, ex_wb_q, mem_wb_q, wb_q;
    logic             dec_reg2loc;
    logic [REG_W-1:0] rn, rt, src2;
    logic [3:0]       cond;
    logic [3:0]       nzvc_q, ex_flags, branch_flags;
    logic             load_use, cb_hazard, branch_cond;

    ctrl_decode #(.XFER_W(XFER_W), .REG_W(REG_W)) u_decode (
        .instr_valid (instr_valid),
        .instruction (instruction),
        .op          (op),
        .ex_bundle   (dec_ex),
        .mem_bundle  (dec_mem),
        .wb_bundle   (dec_wb),
        .reg2loc     (dec_reg2loc),
        .rn          (rn),
        .rt          (rt),
        .src2        (src2),
        .cond        (cond)
    );

    assign ex_flags     = {ex_negative, ex_zero, ex_overflow, ex_carry};
    assign branch_flags = (ex_q.valid && ex_q.set_flag) ? ex_flags : nzvc_q;
    assign ex_ctrl      = ex_q;
    assign mem_ctrl     = mem_q;
    assign wb_ctrl      = wb_q;

    // Flag-setters in EX are forwarded to B.cond, so they never cause a stall.
    always_comb begin
        load_use  = 1'b0;
        cb_hazard = 1'b0;
        if (instr_valid && ex_mem_q.valid && ex_mem_q.mem_read && ex_wb_q.rd != XZR)
            load_use = (ex_wb_q.rd == rn) || (ex_wb_q.rd == src2);
        if (op == OP_CBZ || op == OP_CBNZ) begin
            if (ex_wb_q.valid && ex_wb_q.reg_write && ex_wb_q.rd == rt && rt != XZR)
                cb_hazard = 1'b1;
            if (mem_q.valid && mem_q.mem_read && mem_wb_q.rd == rt && rt != XZR)
                cb_hazard = 1'b1;
        end
        branch_cond = (op == OP_B)
                   || (op == OP_BCOND && cond_holds(cond, branch_flags))
                   || (op == OP_CBZ   && rd_is_zero)
                   || (op == OP_CBNZ  && !rd_is_zero);
    end

    always_comb begin
        stall     = 1'b0;
        br_taken  = 1'b0;
        flush_if  = 1'b0;
        uncond_br = 1'b0;
        reg2loc   = 1'b0;
        if (!reset) begin
            stall     = load_use || cb_hazard;
            br_taken  = branch_cond && !stall;
            flush_if  = br_taken;
            uncond_br = (op == OP_B);
            reg2loc   = dec_reg2loc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nzvc_q   <= 4'b0000;
            ex_q     <= EX_BUBBLE;
            ex_mem_q <= MEM_BUBBLE;
            ex_wb_q  <= WB_BUBBLE;
            mem_q    <= MEM_BUBBLE;
            mem_wb_q <= WB_BUBBLE;
            wb_q     <= WB_BUBBLE;
        end else begin
            if (ex_q.valid && ex_q.set_flag)
                nzvc_q <= ex_flags;
            ex_q     <= stall ? EX_BUBBLE  : dec_ex;
            ex_mem_q <= stall ? MEM_BUBBLE : dec_mem;
            ex_wb_q  <= stall ? WB_BUBBLE  : dec_wb;
            mem_q    <= ex_mem_q;
            mem_wb_q <= ex_wb_q;
            wb_q     <= mem_wb_q;
        end
    end

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: one instruction per cycle from a fixed
// program, checked with immediate assertions against hand-derived values.
module tb_pipe_control;
    import pipe_control_pkg::*;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instruction;
    logic        rd_is_zero;
    logic        ex_negative, ex_zero, ex_overflow, ex_carry;
    logic        stall, flush_if, br_taken, uncond_br, reg2loc;
    ex_ctrl_t    ex_ctrl;
    mem_ctrl_t   mem_ctrl;
    wb_ctrl_t    wb_ctrl;

    int compare_count  = 0;
    int mismatch_count = 0;

    ex_ctrl_t  exp_ex;
    mem_ctrl_t exp_mem;
    wb_ctrl_t  exp_wb;

    localparam logic [31:0] I_SUBS   = {11'b11101011000, 5'd3, 6'd0, 5'd2, 5'd1};
    localparam logic [31:0] I_BEQ    = {8'b01010100, 19'd4, 5'b00000};
    localparam logic [31:0] I_BNE    = {8'b01010100, 19'd4, 5'b00001};
    localparam logic [31:0] I_BGE    = {8'b01010100, 19'd4, 5'b01010};
    localparam logic [31:0] I_BNV    = {8'b01010100, 19'd4, 5'b01111};
    localparam logic [31:0] I_LDUR5  = {11'b11111000010, 9'd0, 2'b00, 5'd1, 5'd5};
    localparam logic [31:0] I_LDUR31 = {11'b11111000010, 9'd0, 2'b00, 5'd1, 5'd31};
    localparam logic [31:0] I_LDURB7 = {11'b00111000010, 9'd0, 2'b00, 5'd1, 5'd7};
    localparam logic [31:0] I_STURB  = {11'b00111000000, 9'd0, 2'b00, 5'd1, 5'd2};
    localparam logic [31:0] I_ADDS   = {11'b10101011000, 5'd7, 6'd0, 5'd5, 5'd6};
    localparam logic [31:0] I_ADDI0  = {10'b1001000100, 12'd1, 5'd31, 5'd0};
    localparam logic [31:0] I_ADDI4  = {10'b1001000100, 12'd1, 5'd1, 5'd4};
    localparam logic [31:0] I_CBNZ4  = {8'b10110101, 19'd2, 5'd4};
    localparam logic [31:0] I_B      = {6'b000101, 26'd8};
    localparam logic [31:0] I_UNDEF  = 32'h0000_0000;

    pipe_control dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .rd_is_zero  (rd_is_zero),
        .ex_negative (ex_negative),
        .ex_zero     (ex_zero),
        .ex_overflow (ex_overflow),
        .ex_carry    (ex_carry),
        .stall       (stall),
        .flush_if    (flush_if),
        .br_taken    (br_taken),
        .uncond_br   (uncond_br),
        .reg2loc     (reg2loc),
        .ex_ctrl     (ex_ctrl),
        .mem_ctrl    (mem_ctrl),
        .wb_ctrl     (wb_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one ID-stage slot just after a rising edge, then park on the falling edge.
    task automatic applyStimulus(input logic rst, input logic [31:0] ins,
                                 input logic rz, input logic [3:0] nzvc);
        @(posedge clk);
        #1;
        reset       = rst;
        instr_valid = 1'b1;
        instruction = ins;
        rd_is_zero  = rz;
        {ex_negative, ex_zero, ex_overflow, ex_carry} = nzvc;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        assert (observed === expected)
        else begin
            mismatch_count++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instruction = I_UNDEF;
        rd_is_zero  = 1'b0;
        {ex_negative, ex_zero, ex_overflow, ex_carry} = 4'b0000;

        // Reset: combinational outputs quiet even with a B in ID, stages empty.
        applyStimulus(1'b1, I_B, 1'b0, 4'b0000);
        checkOutput("rst_br_taken", 32'(br_taken), 32'd0);
        checkOutput("rst_uncond", 32'(uncond_br), 32'd0);
        checkOutput("rst_flush", 32'(flush_if), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_ex", 32'(ex_ctrl), 32'd0);
        checkOutput("rst_mem", 32'(mem_ctrl), 32'd0);
        checkOutput("rst_wb", 32'(wb_ctrl), 32'd0);

        applyStimulus(1'b0, I_SUBS, 1'b0, 4'b0000);
        checkOutput("subs_reg2loc", 32'(reg2loc), 32'd1);
        checkOutput("subs_ex_bubble", 32'(ex_ctrl.valid), 32'd0);

        // B.EQ behind SUBS: Z forwarded from the EX flags.
        applyStimulus(1'b0, I_BEQ, 1'b0, 4'b0100);
        exp_ex = '{alu_op: ALU_SUB, alu_src: SRC_REG, set_flag: 1'b1, valid: 1'b1};
        checkOutput("subs_ex", 32'(ex_ctrl), 32'(exp_ex));
        checkOutput("beq_fwd_taken", 32'(br_taken), 32'd1);
        checkOutput("beq_flush", 32'(flush_if), 32'd1);
        checkOutput("beq_stall", 32'(stall), 32'd0);

        // B.NE reads the latched Z=1, EX flags are ignored (no setter in EX).
        applyStimulus(1'b0, I_BNE, 1'b0, 4'b0000);
        checkOutput("bne_reg_flags", 32'(br_taken), 32'd0);

        applyStimulus(1'b0, I_LDUR5, 1'b0, 4'b0000);
        checkOutput("ldur_stall", 32'(stall), 32'd0);

        applyStimulus(1'b0, I_ADDS, 1'b0, 4'b0000);
        checkOutput("loaduse_stall", 32'(stall), 32'd1);

        applyStimulus(1'b0, I_ADDS, 1'b0, 4'b0000);
        checkOutput("loaduse_retry_stall", 32'(stall), 32'd0);
        checkOutput("loaduse_ex_bubble", 32'(ex_ctrl.valid), 32'd0);

        applyStimulus(1'b0, I_UNDEF, 1'b0, 4'b0000);
        exp_ex = '{alu_op: ALU_ADD, alu_src: SRC_REG, set_flag: 1'b1, valid: 1'b1};
        checkOutput("adds_ex", 32'(ex_ctrl), 32'(exp_ex));
        checkOutput("bubble_mem", 32'(mem_ctrl.valid), 32'd0);
        exp_wb = '{reg_write: 1'b1, mem_to_reg: WB_MEM, rd: 5'd5, valid: 1'b1};
        checkOutput("ldur_wb", 32'(wb_ctrl), 32'(exp_wb));
        checkOutput("undef_br", 32'(br_taken), 32'd0);

        applyStimulus(1'b0, I_LDUR31, 1'b0, 4'b0000);
        applyStimulus(1'b0, I_ADDI0, 1'b0, 4'b0000);
        checkOutput("xzr_no_stall", 32'(stall), 32'd0);
        checkOutput("addi_reg2loc", 32'(reg2loc), 32'd0);

        // CBNZ X4 behind ADDI X4: stall masks a would-be-taken branch, then retry.
        applyStimulus(1'b0, I_ADDI4, 1'b0, 4'b0000);
        applyStimulus(1'b0, I_CBNZ4, 1'b0, 4'b0000);
        checkOutput("cbnz_stall", 32'(stall), 32'd1);
        checkOutput("cbnz_stall_br", 32'(br_taken), 32'd0);
        checkOutput("cbnz_stall_flush", 32'(flush_if), 32'd0);
        applyStimulus(1'b0, I_CBNZ4, 1'b0, 4'b0000);
        checkOutput("cbnz_retry_stall", 32'(stall), 32'd0);
        checkOutput("cbnz_retry_br", 32'(br_taken), 32'd1);
        checkOutput("cbnz_retry_flush", 32'(flush_if), 32'd1);

        applyStimulus(1'b0, I_STURB, 1'b0, 4'b0000);
        exp_ex = '{alu_op: ALU_PASSB, alu_src: SRC_REG, set_flag: 1'b0, valid: 1'b1};
        checkOutput("cbnz_ex", 32'(ex_ctrl), 32'(exp_ex));
        checkOutput("sturb_reg2loc", 32'(reg2loc), 32'd0);
        applyStimulus(1'b0, I_UNDEF, 1'b0, 4'b0000);
        exp_ex = '{alu_op: ALU_ADD, alu_src: SRC_DADDR, set_flag: 1'b0, valid: 1'b1};
        checkOutput("sturb_ex", 32'(ex_ctrl), 32'(exp_ex));
        applyStimulus(1'b0, I_UNDEF, 1'b0, 4'b0000);
        exp_mem = '{mem_write: 1'b1, mem_read: 1'b0, load_b: 1'b0, xfer_size: 4'd1, valid: 1'b1};
        checkOutput("sturb_mem", 32'(mem_ctrl), 32'(exp_mem));
        applyStimulus(1'b0, I_UNDEF, 1'b0, 4'b0000);
        exp_wb = '{reg_write: 1'b0, mem_to_reg: WB_ALU, rd: 5'd2, valid: 1'b1};
        checkOutput("sturb_wb", 32'(wb_ctrl), 32'(exp_wb));

        // Latch N=1,V=0 so B.GE is false until reset clears NZVC.
        applyStimulus(1'b0, I_SUBS, 1'b0, 4'b0000);
        applyStimulus(1'b0, I_ADDI4, 1'b0, 4'b1000);
        applyStimulus(1'b0, I_BGE, 1'b0, 4'b0000);
        checkOutput("bge_pre_reset", 32'(br_taken), 32'd0);
        applyStimulus(1'b1, I_BGE, 1'b0, 4'b0000);
        checkOutput("inflight_ex_valid", 32'(ex_ctrl.valid), 32'd1);
        checkOutput("reset_br_taken", 32'(br_taken), 32'd0);
        applyStimulus(1'b0, I_BGE, 1'b0, 4'b1000);
        checkOutput("post_rst_ex", 32'(ex_ctrl.valid), 32'd0);
        checkOutput("post_rst_mem", 32'(mem_ctrl.valid), 32'd0);
        checkOutput("post_rst_wb", 32'(wb_ctrl.valid), 32'd0);
        checkOutput("bge_post_reset", 32'(br_taken), 32'd1);

        applyStimulus(1'b0, I_B, 1'b0, 4'b0000);
        checkOutput("b_uncond", 32'(uncond_br), 32'd1);
        checkOutput("b_taken", 32'(br_taken), 32'd1);
        checkOutput("b_flush", 32'(flush_if), 32'd1);

        applyStimulus(1'b0, I_LDURB7, 1'b0, 4'b0000);
        checkOutput("ldurb_uncond", 32'(uncond_br), 32'd0);
        applyStimulus(1'b0, I_BNV, 1'b0, 4'b0000);
        exp_ex = '{alu_op: ALU_ADD, alu_src: SRC_DADDR, set_flag: 1'b0, valid: 1'b1};
        checkOutput("ldurb_ex", 32'(ex_ctrl), 32'(exp_ex));
        checkOutput("bnv_always", 32'(br_taken), 32'd1);
        applyStimulus(1'b0, I_UNDEF, 1'b0, 4'b0000);
        exp_mem = '{mem_write: 1'b0, mem_read: 1'b1, load_b: 1'b1, xfer_size: 4'd1, valid: 1'b1};
        checkOutput("ldurb_mem", 32'(mem_ctrl), 32'(exp_mem));
        applyStimulus(1'b0, I_UNDEF, 1'b0, 4'b0000);
        exp_wb = '{reg_write: 1'b1, mem_to_reg: WB_MEM, rd: 5'd7, valid: 1'b1};
        checkOutput("ldurb_wb", 32'(wb_ctrl), 32'(exp_wb));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule

// File: doc/pipe_control.md
PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 SHALL have parameter XFER_W, default 4: width of the transfer-size field (bytes).
REQ-002 SHALL have parameter REG_W, default 5: width of register index; index 2**REG_W-1 is XZR.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high.
REQ-005 SHALL have port instr_valid  in  1  ID-stage instruction present.
REQ-006 SHALL have port instruction  in  32  ID-stage LEGv8 instruction.
REQ-007 SHALL have port rd_is_zero  in  1  ID register-read operand (Rt) equals 0, for CBZ.
REQ-008 SHALL have ports ex_negative, ex_zero, ex_overflow, ex_carry  in  1 each  EX-stage ALU flags.
REQ-009 SHALL have port stall  out  1  hold PC and IF/ID; bubble into EX.
REQ-010 SHALL have port flush_if  out  1  squash the IF-stage instruction.
REQ-011 SHALL have ports br_taken, uncond_br, reg2loc  out  1 each  ID-stage branch/read-select.
REQ-012 SHALL have port ex_ctrl  out  ex_ctrl_t  alu_op[2:0], alu_src[1:0], set_flag, valid.
REQ-013 SHALL have port mem_ctrl  out  mem_ctrl_t  mem_write, mem_read, load_b, xfer_size[XFER_W-1:0], valid.
REQ-014 SHALL have port wb_ctrl  out  wb_ctrl_t  reg_write, mem_to_reg[1:0], rd[REG_W-1:0], valid.

Function
REQ-015 SHALL decode ADDI, ADDS, SUBS, B, B.cond, CBZ, CBNZ, LDUR, LDURB, STUR, STURB, MOVZ, MOVK from instruction[31:21] with the existing single-cycle encodings, plus CBNZ = 10110101XXX.
REQ-016 SHALL treat undefined opcodes, instr_valid=0, and stalled slots as bubbles: all write enables, set_flag and valid 0.
REQ-017 SHALL register the decoded bundle ID->EX->MEM->WB; ex_ctrl is one cycle after ID, mem_ctrl two, wb_ctrl three.
REQ-018 SHALL hold a NZVC flag register, updated at EX end only when ex_ctrl.valid and set_flag.
REQ-019 SHALL evaluate B.cond in ID on all 15 conditions of instruction[3:0] (EQ..LE, AL; 1111 = AL).
REQ-020 SHALL forward ex_* flags to B.cond when the EX-stage instruction has set_flag; otherwise use the flag register.
REQ-021 SHALL resolve CBZ as rd_is_zero and CBNZ as !rd_is_zero; B always taken, uncond_br=1.
REQ-022 SHALL assert flush_if the same cycle br_taken=1 and stall=0.
REQ-023 SHALL assert stall for load-use: EX is LDUR/LDURB, its rd != XZR, and rd equals ID Rn or ID second source (Rm if reg2loc, else Rt).
REQ-024 SHALL assert stall for CBZ/CBNZ when EX (any reg_write) or MEM (load) writes the ID Rt, rd != XZR.
REQ-025 SHALL suppress br_taken and flush_if while stall=1; the branch re-resolves on the retry cycle.
REQ-026 SHALL set xfer_size = 8 for 64-bit, 1 for byte ops; load_b=1 only for LDURB.
REQ-027 SHALL give precedence stall > branch in the same cycle; a flag-setting EX with a dependent B.cond in ID SHALL NOT stall.

Reset
REQ-028 SHALL, while reset, drive stall, flush_if, br_taken, uncond_br, reg2loc to 0 and clear every stage bundle to bubble.
REQ-029 SHALL clear NZVC to 0000 on reset; reset asserted mid-pipeline discards all in-flight control.

Structure
REQ-030 SHALL place opcode constants, condition codes, ex_ctrl_t, mem_ctrl_t, wb_ctrl_t in package pipe_control_pkg.
REQ-031 SHALL implement decode as combinational sub-module ctrl_decode; hazard, branch and stage registers live in pipe_control.

Verification
REQ-032 SUBS X1,X2,X3 with X2=X3, next cycle B.EQ -> ex_zero forwarded, br_taken=1, flush_if=1 same cycle.
REQ-033 LDUR X5 then ADDS X6,X5,X7 -> stall=1 exactly one cycle, ex_ctrl.valid=0 that cycle, ADDS reaches EX next.
REQ-034 LDUR X31 then ADDI X0,X31,#1 -> stall=0.
REQ-035 CBNZ X4 with ADDI X4 in EX -> stall=1, br_taken=0; next cycle rd_is_zero=0 -> br_taken=1.
REQ-036 STURB -> mem_ctrl: mem_write=1, xfer_size=1, two cycles after ID; wb_ctrl.reg_write=0.
REQ-037 reset asserted with three instructions in flight -> next cycle all valid=0, NZVC=0000; B.GE then taken (N=V).
